// File: rtl/axis_width_adapter.sv
// AXI-Stream byte-granular width converter: downsize, upsize or equal-width register slice.
// Each mode adds exactly one registered stage between input and output.

module axis_width_adapter_lane #(
  parameter int DW = 8,
  parameter int KW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic [KW-1:0] kin,
  output logic [DW-1:0] dout,
  output logic [KW-1:0] kout
);
  logic [DW-1:0] acc_d;
  logic [KW-1:0] acc_k;

  // clr wins over wr: the completing beat leaves through the bypass below, not the register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_d <= '0;
      acc_k <= '0;
    end else if (wr) begin
      acc_d <= din;
      acc_k <= kin;
    end
  end

  assign dout = wr ? din : acc_d;
  assign kout = wr ? kin : acc_k;
endmodule

module axis_width_adapter #(
  parameter int INPUT_DATA_WIDTH  = 64,
  parameter int INPUT_KEEP_WIDTH  = INPUT_DATA_WIDTH/8,
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH/8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUT_DATA_WIDTH-1:0]  input_axis_tdata,
  input  logic [INPUT_KEEP_WIDTH-1:0]  input_axis_tkeep,
  input  logic                         input_axis_tvalid,
  output logic                         input_axis_tready,
  input  logic                         input_axis_tlast,
  input  logic                         input_axis_tuser,
  output logic [OUTPUT_DATA_WIDTH-1:0] output_axis_tdata,
  output logic [OUTPUT_KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                         output_axis_tvalid,
  input  logic                         output_axis_tready,
  output logic                         output_axis_tlast,
  output logic                         output_axis_tuser
);
  localparam int MIN_KEEP = (INPUT_KEEP_WIDTH < OUTPUT_KEEP_WIDTH) ? INPUT_KEEP_WIDTH : OUTPUT_KEEP_WIDTH;
  localparam int MAX_KEEP = (INPUT_KEEP_WIDTH < OUTPUT_KEEP_WIDTH) ? OUTPUT_KEEP_WIDTH : INPUT_KEEP_WIDTH;
  localparam int R        = MAX_KEEP / MIN_KEEP;
  localparam int SEG_W    = (R > 1) ? $clog2(R) : 1;
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(R-1);

  if ((MAX_KEEP % MIN_KEEP) != 0 || INPUT_DATA_WIDTH != 8*INPUT_KEEP_WIDTH ||
      OUTPUT_DATA_WIDTH != 8*OUTPUT_KEEP_WIDTH) begin : g_bad_ratio
    $error("axis_width_adapter: widths must be byte-granular integer multiples of each other");
  end

  if (INPUT_KEEP_WIDTH > OUTPUT_KEEP_WIDTH) begin : g_down
    typedef enum logic {S_IDLE, S_SEND} state_t;
    state_t state, state_nxt;

    logic [INPUT_DATA_WIDTH-1:0] wbuf_data;
    logic [INPUT_KEEP_WIDTH-1:0] wbuf_keep;
    logic                        wbuf_last, wbuf_user;
    logic [SEG_W-1:0]            seg, end_seg, end_seg_in;
    logic                        seg_acc, final_acc, ready, load, at_end;

    // a last word stops at its highest populated segment; an empty last word still emits segment 0
    always_comb begin
      end_seg_in = SEG_LAST;
      if (input_axis_tlast) begin
        end_seg_in = '0;
        for (int i = 0; i < R; i++)
          if (|input_axis_tkeep[i*OUTPUT_KEEP_WIDTH +: OUTPUT_KEEP_WIDTH]) end_seg_in = SEG_W'(i);
      end
    end

    assign at_end    = (seg == end_seg);
    assign seg_acc   = (state == S_SEND) && output_axis_tready;
    assign final_acc = seg_acc && at_end;
    assign ready     = !rst && ((state == S_IDLE) || final_acc);
    assign load      = input_axis_tvalid && ready;

    always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      case (state)
        S_IDLE: if (load) state_nxt = S_SEND;
        S_SEND: if (final_acc && !load) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wbuf_data <= '0;
        wbuf_keep <= '0;
        wbuf_last <= 1'b0;
        wbuf_user <= 1'b0;
        seg       <= '0;
        end_seg   <= '0;
      end else if (load) begin
        wbuf_data <= input_axis_tdata;
        wbuf_keep <= input_axis_tkeep;
        wbuf_last <= input_axis_tlast;
        wbuf_user <= input_axis_tuser;
        seg       <= '0;
        end_seg   <= end_seg_in;
      end else if (seg_acc && !final_acc) begin
        seg <= seg + 1'b1;
      end
    end

    always_comb begin
      output_axis_tvalid = (state == S_SEND);
      output_axis_tdata  = wbuf_data[seg*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
      output_axis_tkeep  = wbuf_keep[seg*OUTPUT_KEEP_WIDTH +: OUTPUT_KEEP_WIDTH];
      output_axis_tlast  = (state == S_SEND) && wbuf_last && at_end;
      output_axis_tuser  = (state == S_SEND) && wbuf_last && at_end && wbuf_user;
      input_axis_tready  = ready;
    end
  end else begin : g_up
    // equal widths fall out of this path with R = 1: every beat completes a word
    logic [SEG_W-1:0]                            k;
    logic                                        acc_user;
    logic                                        out_valid, out_last, out_user;
    logic [OUTPUT_DATA_WIDTH-1:0]                out_data;
    logic [OUTPUT_KEEP_WIDTH-1:0]                out_keep;
    logic [R-1:0][INPUT_DATA_WIDTH-1:0]          seg_data;
    logic [R-1:0][INPUT_KEEP_WIDTH-1:0]          seg_keep;
    logic [R-1:0]                                lane_wr;
    logic                                        ready, accept, complete;

    assign ready    = !rst && (!out_valid || output_axis_tready);
    assign accept   = input_axis_tvalid && ready;
    assign complete = accept && ((k == SEG_LAST) || input_axis_tlast);

    for (genvar i = 0; i < R; i++) begin : g_lane
      assign lane_wr[i] = accept && (k == SEG_W'(i));
      axis_width_adapter_lane #(.DW(INPUT_DATA_WIDTH), .KW(INPUT_KEEP_WIDTH)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .wr   (lane_wr[i]),
        .clr  (complete),
        .din  (input_axis_tdata),
        .kin  (input_axis_tkeep),
        .dout (seg_data[i]),
        .kout (seg_keep[i])
      );
    end

    // lanes above k are still clear from the previous completion, so short words zero-fill
    always_ff @(posedge clk) begin
      if (rst) begin
        k         <= '0;
        acc_user  <= 1'b0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_keep  <= '0;
        out_last  <= 1'b0;
        out_user  <= 1'b0;
      end else begin
        if (out_valid && output_axis_tready) out_valid <= 1'b0;
        if (complete) begin
          k         <= '0;
          acc_user  <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= seg_data;
          out_keep  <= seg_keep;
          out_last  <= input_axis_tlast;
          out_user  <= acc_user | input_axis_tuser;
        end else if (accept) begin
          k        <= k + 1'b1;
          acc_user <= acc_user | input_axis_tuser;
        end
      end
    end

    assign output_axis_tvalid = out_valid;
    assign output_axis_tdata  = out_data;
    assign output_axis_tkeep  = out_keep;
    assign output_axis_tlast  = out_last;
    assign output_axis_tuser  = out_user;
    assign input_axis_tready  = ready;
  end
endmodule

// File: tb/tb_axis_width_adapter.sv
// Bench for axis_width_adapter: 64->8, 8->64 and 32->32 instances against a queue-based stream model,
// plus directed literal expectations.

module tb_axis_width_adapter;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string nm [3] = '{"dn", "up", "eq"};

  logic [63:0] dn_idata; logic [7:0] dn_ikeep; logic dn_ivalid, dn_iready, dn_ilast, dn_iuser;
  logic [7:0]  dn_odata; logic [0:0] dn_okeep; logic dn_ovalid, dn_oready, dn_olast, dn_ouser;
  logic [7:0]  up_idata; logic [0:0] up_ikeep; logic up_ivalid, up_iready, up_ilast, up_iuser;
  logic [63:0] up_odata; logic [7:0] up_okeep; logic up_ovalid, up_oready, up_olast, up_ouser;
  logic [31:0] eq_idata; logic [3:0] eq_ikeep; logic eq_ivalid, eq_iready, eq_ilast, eq_iuser;
  logic [31:0] eq_odata; logic [3:0] eq_okeep; logic eq_ovalid, eq_oready, eq_olast, eq_ouser;

  axis_width_adapter #(.INPUT_DATA_WIDTH(64), .OUTPUT_DATA_WIDTH(8)) u_dn (
    .clk(clk), .rst(rst),
    .input_axis_tdata(dn_idata), .input_axis_tkeep(dn_ikeep), .input_axis_tvalid(dn_ivalid),
    .input_axis_tready(dn_iready), .input_axis_tlast(dn_ilast), .input_axis_tuser(dn_iuser),
    .output_axis_tdata(dn_odata), .output_axis_tkeep(dn_okeep), .output_axis_tvalid(dn_ovalid),
    .output_axis_tready(dn_oready), .output_axis_tlast(dn_olast), .output_axis_tuser(dn_ouser));

  axis_width_adapter #(.INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(64)) u_up (
    .clk(clk), .rst(rst),
    .input_axis_tdata(up_idata), .input_axis_tkeep(up_ikeep), .input_axis_tvalid(up_ivalid),
    .input_axis_tready(up_iready), .input_axis_tlast(up_ilast), .input_axis_tuser(up_iuser),
    .output_axis_tdata(up_odata), .output_axis_tkeep(up_okeep), .output_axis_tvalid(up_ovalid),
    .output_axis_tready(up_oready), .output_axis_tlast(up_olast), .output_axis_tuser(up_ouser));

  axis_width_adapter #(.INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(32)) u_eq (
    .clk(clk), .rst(rst),
    .input_axis_tdata(eq_idata), .input_axis_tkeep(eq_ikeep), .input_axis_tvalid(eq_ivalid),
    .input_axis_tready(eq_iready), .input_axis_tlast(eq_ilast), .input_axis_tuser(eq_iuser),
    .output_axis_tdata(eq_odata), .output_axis_tkeep(eq_okeep), .output_axis_tvalid(eq_ovalid),
    .output_axis_tready(eq_oready), .output_axis_tlast(eq_olast), .output_axis_tuser(eq_ouser));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream model: expected output beats per instance, oldest first
  beat_t       q [3][$];
  int          hs [3];
  logic        hold [3];
  beat_t       prev [3];
  logic [63:0] acc_d;
  logic [7:0]  acc_k;
  logic        acc_u;
  int          acc_n;

  task automatic model_push(input int id, input beat_t b);
    beat_t e;
    int n;
    case (id)
      0: begin
        n = 8;
        if (b.l) begin
          n = 1;
          for (int i = 0; i < 8; i++) if (b.k[i]) n = i + 1;
        end
        for (int i = 0; i < n; i++) begin
          e.d = {56'h0, b.d[i*8 +: 8]};
          e.k = {7'h0, b.k[i]};
          e.l = b.l && (i == n - 1);
          e.u = b.u && e.l;
          q[0].push_back(e);
        end
      end
      1: begin
        acc_d[acc_n*8 +: 8] = b.d[7:0];
        acc_k[acc_n] = b.k[0];
        acc_u = acc_u | b.u;
        if (acc_n == 7 || b.l) begin
          e.d = acc_d; e.k = acc_k; e.l = b.l; e.u = acc_u;
          q[1].push_back(e);
          acc_d = '0; acc_k = '0; acc_u = 1'b0; acc_n = 0;
        end else acc_n++;
      end
      default: q[2].push_back(b);
    endcase
  endtask

  always @(negedge clk) begin
    logic  ov [3], orr [3], iv [3], ir [3];
    beat_t ob [3], ib [3];
    beat_t e;
    logic  exp_r;
    ov[0] = dn_ovalid; orr[0] = dn_oready; iv[0] = dn_ivalid; ir[0] = dn_iready;
    ov[1] = up_ovalid; orr[1] = up_oready; iv[1] = up_ivalid; ir[1] = up_iready;
    ov[2] = eq_ovalid; orr[2] = eq_oready; iv[2] = eq_ivalid; ir[2] = eq_iready;
    ob[0] = {56'h0, dn_odata, 7'h0, dn_okeep, dn_olast, dn_ouser};
    ob[1] = {up_odata, up_okeep, up_olast, up_ouser};
    ob[2] = {32'h0, eq_odata, 4'h0, eq_okeep, eq_olast, eq_ouser};
    ib[0] = {dn_idata, dn_ikeep, dn_ilast, dn_iuser};
    ib[1] = {56'h0, up_idata, 7'h0, up_ikeep, up_ilast, up_iuser};
    ib[2] = {32'h0, eq_idata, 4'h0, eq_ikeep, eq_ilast, eq_iuser};
    for (int id = 0; id < 3; id++) begin
      if (rst) begin
        chk($sformatf("%s_ready_in_reset", nm[id]), ir[id], 1'b0);
        q[id].delete();
        hold[id] = 1'b0;
        if (id == 1) begin acc_d = '0; acc_k = '0; acc_u = 1'b0; acc_n = 0; end
      end else begin
        chk($sformatf("%s_valid", nm[id]), ov[id], q[id].size() != 0);
        exp_r = (id == 0) ? (q[id].size() == 0 || (q[id].size() == 1 && ov[id] && orr[id]))
                          : (q[id].size() == 0 || orr[id]);
        chk($sformatf("%s_ready", nm[id]), ir[id], exp_r);
        if (hold[id]) chk($sformatf("%s_stable", nm[id]), {ov[id], ob[id]}, {1'b1, prev[id]});
        if (ov[id] && orr[id] && q[id].size() != 0) begin
          e = q[id].pop_front();
          chk($sformatf("%s_beat%0d", nm[id], hs[id]), ob[id], e);
          hs[id]++;
        end
        hold[id] = ov[id] && !orr[id];
        prev[id] = ob[id];
        if (iv[id] && ir[id]) model_push(id, ib[id]);
      end
    end
  end

  // Call aligned just after a rising edge; returns just after the handshake edge
  task automatic put(input int id, input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    logic ok = 1'b0;
    case (id)
      0: begin dn_idata = d; dn_ikeep = k; dn_ilast = l; dn_iuser = u; dn_ivalid = 1'b1; end
      1: begin up_idata = d[7:0]; up_ikeep = k[0:0]; up_ilast = l; up_iuser = u; up_ivalid = 1'b1; end
      default: begin eq_idata = d[31:0]; eq_ikeep = k[3:0]; eq_ilast = l; eq_iuser = u; eq_ivalid = 1'b1; end
    endcase
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = (id == 0) ? dn_iready : (id == 1) ? up_iready : eq_iready;
    end
    chk($sformatf("%s_put_handshake", nm[id]), ok, 1'b1);
    @(posedge clk); #1;
    case (id)
      0: dn_ivalid = 1'b0;
      1: up_ivalid = 1'b0;
      default: eq_ivalid = 1'b0;
    endcase
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int h0;
    logic [31:0] ev [4] = '{32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'h0badf00d};
    logic [3:0]  ek [4] = '{4'hf, 4'h3, 4'h1, 4'h7};
    rst = 1'b1;
    {dn_idata, dn_ikeep, dn_ivalid, dn_ilast, dn_iuser} = '0;
    {up_idata, up_ikeep, up_ivalid, up_ilast, up_iuser} = '0;
    {eq_idata, eq_ikeep, eq_ivalid, eq_ilast, eq_iuser} = '0;
    dn_oready = 1'b1; up_oready = 1'b1; eq_oready = 1'b1;
    acc_d = '0; acc_k = '0; acc_u = 1'b0; acc_n = 0;
    for (int i = 0; i < 3; i++) begin hs[i] = 0; hold[i] = 1'b0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("dn_reset_out", {dn_ovalid, dn_odata, dn_okeep, dn_olast, dn_ouser}, '0);
    chk("up_reset_out", {up_ovalid, up_odata, up_okeep, up_olast, up_ouser}, '0);
    chk("eq_reset_out", {eq_ovalid, eq_odata, eq_okeep, eq_olast, eq_ouser}, '0);
    align(); rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {dn_iready, up_iready, eq_iready}, 3'b111);
    align();

    // 64->8 partial last word: cd,ab,cd,ab,cd on consecutive cycles
    put(0, 64'habcdabcdabcdabcd, 8'h1f, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t1_seg%0d", i), {dn_ovalid, dn_odata, dn_okeep, dn_olast},
          {1'b1, (i % 2 == 0) ? 8'hcd : 8'hab, 1'b1, i == 4});
    end
    @(negedge clk);
    chk("t1_idle", dn_ovalid, 1'b0);
    align();

    // last word with no bytes: one empty beat carrying tlast
    put(0, 64'h1122334455667788, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_empty", {dn_ovalid, dn_odata, dn_okeep, dn_olast, dn_ouser}, {1'b1, 8'h88, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("t6_single", dn_ovalid, 1'b0);
    align();

    // back-to-back full words under alternating backpressure
    h0 = hs[0];
    fork
      begin
        put(0, 64'h0706050403020100, 8'hff, 1'b0, 1'b1);
        put(0, 64'h0f0e0d0c0b0a0908, 8'hff, 1'b1, 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
        dn_oready = (i % 2 == 0);
        align();
      end
    join
    dn_oready = 1'b1;
    repeat (10) align();
    chk("t2_beats", hs[0] - h0, 16);

    put(0, 64'h8877665544332211, 8'h21, 1'b1, 1'b1);
    repeat (8) align();

    // 8->64 short word with tuser mid-frame
    put(1, 64'h11, 8'h1, 1'b0, 1'b0);
    put(1, 64'h22, 8'h1, 1'b0, 1'b1);
    put(1, 64'h33, 8'h1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_word", {up_ovalid, up_odata, up_okeep, up_olast, up_ouser},
        {1'b1, 64'h0000000000332211, 8'h07, 1'b1, 1'b1});
    align();
    for (int b = 1; b <= 8; b++) put(1, 64'(b), 8'h1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_full", {up_ovalid, up_odata, up_okeep, up_olast, up_ouser},
        {1'b1, 64'h0807060504030201, 8'hff, 1'b0, 1'b0});
    align();
    up_oready = 1'b0;
    fork
      for (int b = 1; b <= 10; b++) put(1, 64'(8'ha0 + b), 8'h1, b == 10, b == 9);
      begin repeat (12) align(); up_oready = 1'b1; end
    join
    repeat (4) align();

    // 32->32 with idle gaps between beats
    for (int i = 0; i < 4; i++) begin
      put(2, {32'h0, ev[i]}, {4'h0, ek[i]}, i == 3, i == 1);
      @(negedge clk);
      chk($sformatf("t4_beat%0d", i), {eq_ovalid, eq_odata, eq_okeep, eq_olast, eq_ouser},
          {1'b1, ev[i], ek[i], i == 3, i == 1});
      align();
    end

    // reset after two segments of a frame, then a fresh word
    put(0, 64'h8877665544332211, 8'hff, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    align(); rst = 1'b1;
    align();
    @(negedge clk);
    chk("t5_reset_out", {dn_ovalid, dn_odata, dn_okeep, dn_olast, dn_iready}, '0);
    align(); rst = 1'b0;
    align();
    put(0, 64'h000000a5a4a3a2a1, 8'h1f, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_fresh_seg0", {dn_ovalid, dn_odata, dn_okeep, dn_olast}, {1'b1, 8'ha1, 1'b1, 1'b0});
    repeat (8) align();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
